// File: rtl/atm.sv
// atm: transaction controller for a ten-account teller machine.
//
// Every transaction takes the same four-state walk, with no handshake:
// capture the request, authenticate, execute, report. A new transaction
// starts every four cycles.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset; reloads the account database
//   operation  3=inquiry, 4=withdraw, 5=deposit, 6=change PIN, others invalid
//   acc_num    account number, valid 1..10
//   pin        entered PIN (binary)
//   newPin     replacement PIN for operation 6
//   amount     unsigned amount for withdraw / deposit
//   language   UI language select; latched with the request, no datapath effect
//   balance    balance reported by the last executed transaction
//   success    1 = last transaction completed
//   state      current FSM state encoding
//
// Build option
//   ATM_WITHDRAW_LIMIT_EN  when defined, withdrawals above 2000 are refused.
//
// state | meaning
// IDLE  | (7) register the request inputs on the leaving edge
// AUTH  | (1) register the account/PIN check on the leaving edge
// EXEC  | (2) update database, balance and success on the leaving edge
// DONE  | (3) results visible; return to IDLE
module atm (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  operation,
  input  logic [3:0]  acc_num,
  input  logic [15:0] pin,
  input  logic [15:0] newPin,
  input  logic [31:0] amount,
  input  logic        language,
  output logic [31:0] balance,
  output logic        success,
  output logic [2:0]  state
);

  localparam logic [2:0] S_IDLE = 3'd7;
  localparam logic [2:0] S_AUTH = 3'd1;
  localparam logic [2:0] S_EXEC = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;

  localparam logic [2:0] OP_INQ = 3'd3;
  localparam logic [2:0] OP_WD  = 3'd4;
  localparam logic [2:0] OP_DEP = 3'd5;
  localparam logic [2:0] OP_PIN = 3'd6;

  function automatic logic [15:0] default_pin(input logic [3:0] i);
    case (i)
      4'd0:    default_pin = 16'd1234;
      4'd1:    default_pin = 16'd2345;
      4'd2:    default_pin = 16'd3456;
      4'd3:    default_pin = 16'd4567;
      4'd4:    default_pin = 16'd5678;
      4'd5:    default_pin = 16'd6789;
      4'd6:    default_pin = 16'd7890;
      4'd7:    default_pin = 16'd8901;
      4'd8:    default_pin = 16'd9012;
      default: default_pin = 16'd7123;
    endcase
  endfunction

  function automatic logic [31:0] default_bal(input logic [3:0] i);
    case (i)
      4'd0:    default_bal = 32'd1000;
      4'd1:    default_bal = 32'd2000;
      4'd2:    default_bal = 32'd3000;
      4'd3:    default_bal = 32'd4000;
      4'd4:    default_bal = 32'd5000;
      4'd5:    default_bal = 32'd6000;
      4'd6:    default_bal = 32'd7000;
      4'd7:    default_bal = 32'd8000;
      4'd8:    default_bal = 32'd9000;
      default: default_bal = 32'd10000;
    endcase
  endfunction

  logic [2:0]  state_q, state_d;
  logic        capture_en, auth_en, exec_en;

  logic [2:0]  op_r;
  logic [3:0]  acc_r;
  logic [15:0] pin_r;
  logic [15:0] new_pin_r;
  logic [31:0] amount_r;
  // Held only so the request record is complete; nothing reads it.
  logic        lang_r_unused;
  logic        auth_q;

  logic [15:0] pin_db [0:9];
  logic [31:0] bal_db [0:9];

  logic        acc_ok;
  logic [3:0]  idx;
  logic [15:0] stored_pin;
  logic [31:0] stored_bal;
  logic        auth_pass;
  logic [32:0] dep_sum;
  logic        wd_limit_ok;

  logic [31:0] bal_nxt;
  logic        succ_nxt;
  logic        wr_bal;
  logic        wr_pin;
  logic [31:0] bal_wdata;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = S_AUTH;
      S_AUTH:  state_d = S_EXEC;
      S_EXEC:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;  // unused encodings recover to IDLE
    endcase
  end

  // ---------------- FSM: outputs / strobes ----------------
  always_comb begin
    capture_en = 1'b0;
    auth_en    = 1'b0;
    exec_en    = 1'b0;
    state      = state_q;
    case (state_q)
      S_IDLE:  capture_en = 1'b1;
      S_AUTH:  auth_en    = 1'b1;
      S_EXEC:  exec_en    = 1'b1;
      default: ;
    endcase
  end

  // ---------------- Database lookup and authentication ----------------
  // Out-of-range accounts read entry 0; auth_pass masks the result anyway.
  always_comb begin
    acc_ok     = (acc_r >= 4'd1) && (acc_r <= 4'd10);
    idx        = acc_ok ? (acc_r - 4'd1) : 4'd0;
    stored_pin = pin_db[idx];
    stored_bal = bal_db[idx];
    auth_pass  = acc_ok && (pin_r == stored_pin);
    dep_sum    = {1'b0, stored_bal} + {1'b0, amount_r};
  end

`ifdef ATM_WITHDRAW_LIMIT_EN
  assign wd_limit_ok = (amount_r <= 32'd2000);
`else
  assign wd_limit_ok = 1'b1;
`endif

  // ---------------- Execute decision ----------------
  always_comb begin
    bal_nxt   = 32'd0;
    succ_nxt  = 1'b0;
    wr_bal    = 1'b0;
    wr_pin    = 1'b0;
    bal_wdata = stored_bal;
    if (auth_q) begin
      case (op_r)
        OP_INQ: begin
          bal_nxt  = stored_bal;
          succ_nxt = 1'b1;
        end
        OP_WD: begin
          if ((amount_r <= stored_bal) && wd_limit_ok) begin
            bal_wdata = stored_bal - amount_r;
            bal_nxt   = bal_wdata;
            succ_nxt  = 1'b1;
            wr_bal    = 1'b1;
          end else begin
            bal_nxt   = stored_bal;
          end
        end
        OP_DEP: begin
          if (!dep_sum[32]) begin
            bal_wdata = dep_sum[31:0];
            bal_nxt   = bal_wdata;
            succ_nxt  = 1'b1;
            wr_bal    = 1'b1;
          end else begin
            bal_nxt   = stored_bal;
          end
        end
        OP_PIN: begin
          bal_nxt  = stored_bal;
          if (new_pin_r != stored_pin) begin
            succ_nxt = 1'b1;
            wr_pin   = 1'b1;
          end
        end
        default: ;  // invalid opcode: report 0 / fail
      endcase
    end
  end

  // ---------------- Datapath registers and database ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 10; i++) begin
        pin_db[i] <= default_pin(4'(i));
        bal_db[i] <= default_bal(4'(i));
      end
      balance       <= 32'd0;
      success       <= 1'b0;
      op_r          <= 3'd0;
      acc_r         <= 4'd0;
      pin_r         <= 16'd0;
      new_pin_r     <= 16'd0;
      amount_r      <= 32'd0;
      lang_r_unused <= 1'b0;
      auth_q        <= 1'b0;
    end else begin
      if (capture_en) begin
        op_r          <= operation;
        acc_r         <= acc_num;
        pin_r         <= pin;
        new_pin_r     <= newPin;
        amount_r      <= amount;
        lang_r_unused <= language;
      end
      if (auth_en) auth_q <= auth_pass;
      if (exec_en) begin
        balance <= bal_nxt;
        success <= succ_nxt;
        if (wr_bal) bal_db[idx] <= bal_wdata;
        if (wr_pin) pin_db[idx] <= new_pin_r;
      end
    end
  end

endmodule

// File: tb/tb_atm.sv
module tb_atm;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  operation;
  logic [3:0]  acc_num;
  logic [15:0] pin;
  logic [15:0] newPin;
  logic [31:0] amount;
  logic        language;
  logic [31:0] balance;
  logic        success;
  logic [2:0]  state;

  atm dut (
    .clk(clk), .rst(rst), .operation(operation), .acc_num(acc_num),
    .pin(pin), .newPin(newPin), .amount(amount), .language(language),
    .balance(balance), .success(success), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] bal;
    logic        succ;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn_id = 0;

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask

  // Set the request inputs (captured on the next IDLE edge) and queue the result.
  task automatic drive(input logic [2:0] op, input logic [3:0] acc, input logic [15:0] p,
                       input logic [15:0] np, input logic [31:0] amt,
                       input logic [31:0] eb, input logic es);
    exp_t e;
    operation = op; acc_num = acc; pin = p; newPin = np; amount = amt;
    language  = txn_id[0];
    txn_id++;
    e.id = txn_id; e.bal = eb; e.succ = es;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (state != 3'd7 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_val("wait_idle_state", {29'd0, state}, 32'd7);
  endtask

  task automatic go(input logic [2:0] op, input logic [3:0] acc, input logic [15:0] p,
                    input logic [15:0] np, input logic [31:0] amt,
                    input logic [31:0] eb, input logic es);
    wait_idle();
    drive(op, acc, p, np, amt, eb, es);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_val("queue_drained", exp_q.size(), 32'd0);
  endtask

  // Monitor: results are presented during DONE.
  always @(negedge clk) begin
    if (!rst && state == 3'd3 && exp_q.size() != 0) begin
      exp_t e;
      string nm;
      e = exp_q.pop_front();
      nm = $sformatf("txn%0d_balance", e.id);
      check_val(nm, balance, e.bal);
      nm = $sformatf("txn%0d_success", e.id);
      check_val(nm, {31'd0, success}, {31'd0, e.succ});
    end
  end

  localparam logic [15:0] PINS [0:9] = '{16'd1234, 16'd2345, 16'd3456, 16'd4567, 16'd5678,
                                         16'd6789, 16'd7890, 16'd8901, 16'd9012, 16'd7123};

  initial begin
    rst = 1'b1;
    operation = 3'd0; acc_num = 4'd0; pin = 16'd0; newPin = 16'd0;
    amount = 32'd0; language = 1'b0;
    // First transaction: inquiry on account 1, captured on the first non-reset edge.
    drive(3'd3, 4'd1, PINS[0], 16'd0, 32'd0, 32'd1000, 1'b1);
    repeat (2) @(negedge clk);
    check_val("reset_state", {29'd0, state}, 32'd7);
    check_val("reset_balance", balance, 32'd0);
    check_val("reset_success", {31'd0, success}, 32'd0);
    rst = 1'b0;
    @(negedge clk); check_val("seq_auth", {29'd0, state}, 32'd1);
    @(negedge clk); check_val("seq_exec", {29'd0, state}, 32'd2);
    @(negedge clk); check_val("seq_done", {29'd0, state}, 32'd3);
    @(negedge clk); check_val("seq_idle", {29'd0, state}, 32'd7);
    drive(3'd3, 4'd2, PINS[1], 16'd0, 32'd0, 32'd2000, 1'b1);

    for (int k = 3; k <= 10; k++)
      go(3'd3, 4'(k), PINS[k-1], 16'd0, 32'd0, 32'(k * 1000), 1'b1);

    go(3'd5, 4'd3, 16'd3456, 16'd0, 32'd1000, 32'd4000, 1'b1);
    go(3'd4, 4'd3, 16'd3456, 16'd0, 32'd500,  32'd3500, 1'b1);
    go(3'd4, 4'd3, 16'd3456, 16'd0, 32'd3600, 32'd3500, 1'b0);
    go(3'd3, 4'd0,  16'd0,    16'd0, 32'd0, 32'd0, 1'b0);
    go(3'd3, 4'd11, 16'd1234, 16'd0, 32'd0, 32'd0, 1'b0);
    go(3'd3, 4'd15, 16'd7123, 16'd0, 32'd0, 32'd0, 1'b0);
    go(3'd3, 4'd2,  16'd9012, 16'd0, 32'd0, 32'd0, 1'b0);
    go(3'd6, 4'd1, 16'd1234, 16'd1234, 32'd0, 32'd1000, 1'b0);
    go(3'd6, 4'd1, 16'd1234, 16'd5678, 32'd0, 32'd1000, 1'b1);
    go(3'd3, 4'd1, 16'd1234, 16'd0, 32'd0, 32'd0, 1'b0);
    go(3'd3, 4'd1, 16'd5678, 16'd0, 32'd0, 32'd1000, 1'b1);
`ifdef ATM_WITHDRAW_LIMIT_EN
    go(3'd4, 4'd10, 16'd7123, 16'd0, 32'd2500, 32'd10000, 1'b0);
`else
    go(3'd4, 4'd10, 16'd7123, 16'd0, 32'd2500, 32'd7500, 1'b1);
`endif
    go(3'd7, 4'd4, 16'd4567, 16'd0, 32'd0, 32'd0, 1'b0);
    go(3'd0, 4'd4, 16'd4567, 16'd0, 32'd0, 32'd0, 1'b0);
    go(3'd5, 4'd5, 16'd5678, 16'd0, 32'hFFFF_FFFF, 32'd5000, 1'b0);
    go(3'd5, 4'd7, 16'd7890, 16'd0, 32'hFFFF_FFFF - 32'd7000, 32'hFFFF_FFFF, 1'b1);
`ifdef ATM_WITHDRAW_LIMIT_EN
    go(3'd4, 4'd2, 16'd2345, 16'd0, 32'd2000, 32'd0, 1'b1);
`else
    go(3'd4, 4'd6, 16'd6789, 16'd0, 32'd6000, 32'd0, 1'b1);
`endif
    drain();

    // Mid-run reset: outputs clear and the database reloads its defaults.
    wait_idle();
    rst = 1'b1;
    drive(3'd3, 4'd3, 16'd3456, 16'd0, 32'd0, 32'd3000, 1'b1);
    @(negedge clk);
    check_val("rst2_state", {29'd0, state}, 32'd7);
    check_val("rst2_balance", balance, 32'd0);
    check_val("rst2_success", {31'd0, success}, 32'd0);
    rst = 1'b0;
    go(3'd3, 4'd1, 16'd1234, 16'd0, 32'd0, 32'd1000, 1'b1);
    go(3'd3, 4'd7, 16'd7890, 16'd0, 32'd0, 32'd7000, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
